alu_seq_ctrl: RTL and testbench

Sequencer for the 4-lane MAC ALU. It accepts a job start, and gates 8 input-buffer load beats. It then holds the ALU enable for exactly 32 MAC cycles and issues one result-RAM write per 8-cycle row. It sits between the host handshake and the ALU/result RAM. It mirrors the ALU's free-running 5-bit phase counter so that an aborted job never leaves the ALU misaligned.

---
 rtl/mm_pkg.sv | 21 ++
 rtl/alu_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the MAC ALU sequencer.
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int unsigned LOAD_BEATS = 8;
    localparam int unsigned MAC_CYCLES = 32;
    localparam int unsigned ROW_CYCLES = 8;
    localparam int unsigned ALU_PH_W   = 5;

    localparam int unsigned BEAT_W  = $clog2(LOAD_BEATS);
    localparam int unsigned CYC_W   = $clog2(MAC_CYCLES);
    localparam int unsigned ROW_LSB = $clog2(ROW_CYCLES);

endpackage

// File: rtl/alu_seq_ctrl.sv
// Job sequencer for the 4-lane MAC ALU: gates input loads, runs 32 MAC cycles,
// strobes one result-RAM write per row and keeps a mirror of the ALU phase.
module alu_seq_ctrl
    import mm_pkg::*;
#(
    parameter int unsigned JOB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             buf_load,
    output logic [2:0]       buf_idx,
    output logic             alu_en,
    input  logic             alu_done,
    output logic             ram_we,
    output logic [JOB_W+1:0] ram_addr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [ALU_PH_W-1:0]   ph_q, ph_d;
    logic [JOB_W-1:0]      job_q, job_d;
    logic                  err_q, err_d;
    logic                  ph_last;

    // Output decodes of registered state; only buf_load/buf_idx see in_valid.
    assign in_ready = (state_q == ST_LOAD);
    assign buf_load = in_valid & in_ready;
    assign buf_idx  = buf_load ? beat_q : '0;
    assign alu_en   = (state_q == ST_COMPUTE) || (state_q == ST_FLUSH);
    assign ram_we   = (state_q == ST_COMPUTE) &&
                      (cyc_q[ROW_LSB-1:0] == ROW_LSB'(ROW_CYCLES - 1));
    assign ram_addr = {job_q, cyc_q[CYC_W-1:ROW_LSB]};
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;

    assign ph_last  = (ph_q == '1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        job_d   = job_q;
        err_d   = err_q;
        // The mirror free-runs with the ALU so an abort never desynchronises it.
        ph_d    = alu_en ? ph_q + ALU_PH_W'(1) : ph_q;

        if (alu_en && (alu_done != ph_last)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    beat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(LOAD_BEATS - 1)) begin
                        state_d = ST_COMPUTE;
                        cyc_d   = '0;
                        if (ph_q != '0) begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (abort) begin
                    state_d = (ph_d == '0) ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_COMPUTE: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(MAC_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
                // Abort wins over the final cycle; flush only if the ALU is mid-phase.
                if (abort) begin
                    state_d = (ph_d == '0) ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (ph_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                job_d   = job_q + JOB_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            cyc_q   <= '0;
            ph_q    <= '0;
            job_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            ph_q    <= ph_d;
            job_q   <= job_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural ALU phase counter.
module tb_alu_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic       buf_load;
    logic [2:0] buf_idx;
    logic       alu_en;
    logic       alu_done;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic       busy;
    logic       done;
    logic       err;

    int         n_checks;
    int         n_fail;
    logic [3:0] job_exp;

    // Behavioural ALU: free-running phase that advances while enabled.
    logic [4:0] alu_ph;
    logic       force_done;

    wire [15:0] outs = {in_ready, buf_load, buf_idx, alu_en, ram_we, ram_addr, busy, done, err};

    alu_seq_ctrl #(.JOB_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .buf_load (buf_load),
        .buf_idx  (buf_idx),
        .alu_en   (alu_en),
        .alu_done (alu_done),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst)        alu_ph <= 5'd0;
        else if (alu_en) alu_ph <= alu_ph + 5'd1;
    end
    assign alu_done = (alu_ph == 5'd31) | force_done;

    // One job: start, 8 beats, 32 compute cycles, optional abort or fault.
    task automatic run_job(input bit stall, input int abort_cyc, input int fault_cyc);
        int         s;
        int         k;
        int         n;
        bit         aborted;
        bit         exp_we;
        bit         exp_err;
        logic [1:0] row;
        logic [5:0] exp_addr;
        aborted = 1'b0;
        @(negedge clk); start = 1'b1; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_idle busy: got %b want 0", busy); end
        @(negedge clk); start = 1'b0;
        s = 0; k = 0;
        while (k < 8 && s < 100) begin
            in_valid = stall ? (s % 3 == 0) : 1'b1;
            #1;
            n_checks++; if ({in_ready, alu_en, err} !== 3'b100) begin n_fail++; $display("FAIL load_state s=%0d: got rdy/en/err=%b want 100", s, {in_ready, alu_en, err}); end
            if (in_valid) begin
                n_checks++; if ({buf_load, buf_idx} !== {1'b1, 3'(k)}) begin n_fail++; $display("FAIL load_beat k=%0d: got ld/idx=%b/%0d want 1/%0d", k, buf_load, buf_idx, k); end
                k++;
            end else begin
                n_checks++; if (buf_load !== 1'b0) begin n_fail++; $display("FAIL load_stall s=%0d: got buf_load=%b want 0", s, buf_load); end
            end
            s++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL load_timeout: got %0d beats want 8", k); end
        for (int c = 0; c < 32; c++) begin
            #1;
            exp_we   = (c % 8 == 7);
            exp_err  = (fault_cyc >= 0) && (c > fault_cyc);
            row      = 2'(c / 8);
            exp_addr = {job_exp, row};
            n_checks++; if ({alu_en, ram_we, err, done} !== {1'b1, exp_we, exp_err, 1'b0}) begin n_fail++; $display("FAIL compute c=%0d: got en/we/err/done=%b want %b", c, {alu_en, ram_we, err, done}, {1'b1, exp_we, exp_err, 1'b0}); end
            if (exp_we) begin
                n_checks++; if (ram_addr !== exp_addr) begin n_fail++; $display("FAIL ram_addr c=%0d: got %0d want %0d", c, ram_addr, exp_addr); end
            end
            if (c == fault_cyc) force_done = 1'b1;
            if (c == abort_cyc) abort = 1'b1;
            @(negedge clk);
            force_done = 1'b0;
            abort      = 1'b0;
            if (c == abort_cyc) begin
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            #1;
            n_checks++; if ({done, busy, alu_en} !== 3'b110) begin n_fail++; $display("FAIL done_pulse: got done/busy/en=%b want 110", {done, busy, alu_en}); end
            @(negedge clk); #1;
            n_checks++; if ({done, busy, err} !== {2'b00, fault_cyc >= 0}) begin n_fail++; $display("FAIL after_done: got done/busy/err=%b want %b", {done, busy, err}, {2'b00, fault_cyc >= 0}); end
            job_exp++;
        end else if (abort_cyc == 31) begin
            #1;
            n_checks++; if ({busy, done, alu_en, ram_we} !== 4'b0000) begin n_fail++; $display("FAIL abort_last_idle: got busy/done/en/we=%b want 0000", {busy, done, alu_en, ram_we}); end
        end else begin
            n = 0;
            #1;
            while (busy && n < 40) begin
                n_checks++; if ({alu_en, ram_we, in_ready, done} !== 4'b1000) begin n_fail++; $display("FAIL flush n=%0d: got en/we/rdy/done=%b want 1000", n, {alu_en, ram_we, in_ready, done}); end
                n++;
                @(negedge clk); #1;
            end
            n_checks++; if (n != 31 - abort_cyc) begin n_fail++; $display("FAIL flush_len: got %0d want %0d", n, 31 - abort_cyc); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b1; force_done = 1'b0;
        #1;
        n_checks++; if (outs !== 16'h0) begin n_fail++; $display("FAIL reset_outs: got %h want 0000", outs); end
        @(negedge clk); rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        job_exp = 4'd0;
        #1;
        n_checks++; if (outs !== 16'h0) begin n_fail++; $display("FAIL reset_release: got %h want 0000", outs); end
    endtask

    task automatic test_nominal();
        run_job(1'b0, -1, -1);
    endtask

    task automatic test_stalled_load();
        run_job(1'b1, -1, -1);
    endtask

    task automatic test_abort_mid();
        run_job(1'b0, 10, -1);
        run_job(1'b0, -1, -1);
        // Abort coincident with an accepted beat: beat lands, then back to idle.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b1; #1;
        n_checks++; if ({buf_load, buf_idx} !== 4'b1010) begin n_fail++; $display("FAIL abort_load_beat: got ld/idx=%b want 1010", {buf_load, buf_idx}); end
        @(negedge clk); abort = 1'b0; in_valid = 1'b0; #1;
        n_checks++; if ({busy, alu_en, done} !== 3'b000) begin n_fail++; $display("FAIL abort_load_idle: got busy/en/done=%b want 000", {busy, alu_en, done}); end
        run_job(1'b0, -1, -1);
    endtask

    task automatic test_abort_last();
        run_job(1'b0, 31, -1);
        run_job(1'b0, -1, -1);
    endtask

    task automatic test_fault();
        run_job(1'b0, -1, 20);
        repeat (3) begin
            @(negedge clk); #1;
            n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        end
        run_job(1'b0, -1, -1);
    endtask

    task automatic test_wrap();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        job_exp = 4'd0;
        for (int j = 0; j < 17; j++) run_job(1'b0, -1, -1);
    endtask

    task automatic test_rst_mid();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_checks++; if ({alu_en, busy} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_pre: got en/busy=%b want 11", {alu_en, busy}); end
        #2; rst = 1'b0; #1;
        n_checks++; if (outs !== 16'h0) begin n_fail++; $display("FAIL rst_mid_outs: got %h want 0000", outs); end
        @(negedge clk); rst = 1'b1; job_exp = 4'd0;
        @(negedge clk); #1;
        n_checks++; if (outs !== 16'h0) begin n_fail++; $display("FAIL rst_mid_after: got %h want 0000", outs); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_nominal();
        test_stalled_load();
        test_abort_mid();
        test_abort_last();
        test_fault();
        test_wrap();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
